// File: rtl/ifft_stage_2_pipe.sv
// Radix-2 inverse FFT stage 2 (8 points) with a 2-entry skid FIFO.
// Optional 1/2 output scaling: define IFFT_STAGE_SCALE_EN.
module ifft_stage_2_pipe #(
    parameter int N = 3,
    localparam int W = 2 ** N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_0_r,
    input  logic [W-1:0] in_1_r,
    input  logic [W-1:0] in_2_r,
    input  logic [W-1:0] in_3_r,
    input  logic [W-1:0] in_4_r,
    input  logic [W-1:0] in_5_r,
    input  logic [W-1:0] in_6_r,
    input  logic [W-1:0] in_7_r,
    input  logic [W-1:0] in_0_i,
    input  logic [W-1:0] in_1_i,
    input  logic [W-1:0] in_2_i,
    input  logic [W-1:0] in_3_i,
    input  logic [W-1:0] in_4_i,
    input  logic [W-1:0] in_5_i,
    input  logic [W-1:0] in_6_i,
    input  logic [W-1:0] in_7_i,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_0_r,
    output logic [W-1:0] out_1_r,
    output logic [W-1:0] out_2_r,
    output logic [W-1:0] out_3_r,
    output logic [W-1:0] out_4_r,
    output logic [W-1:0] out_5_r,
    output logic [W-1:0] out_6_r,
    output logic [W-1:0] out_7_r,
    output logic [W-1:0] out_0_i,
    output logic [W-1:0] out_1_i,
    output logic [W-1:0] out_2_i,
    output logic [W-1:0] out_3_i,
    output logic [W-1:0] out_4_i,
    output logic [W-1:0] out_5_i,
    output logic [W-1:0] out_6_i,
    output logic [W-1:0] out_7_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ovf,
    input  logic         ovf_clr
);

    logic [W-1:0] x_r [8];
    logic [W-1:0] x_i [8];
    logic signed [W:0] f_r [8];
    logic signed [W:0] f_i [8];
    logic [W-1:0] y_r [8];
    logic [W-1:0] y_i [8];
    logic         any_ovf;

    logic [W-1:0] mem_r [2][8];
    logic [W-1:0] mem_i [2][8];
    logic [1:0]   count;
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;
    logic         pop;

    assign x_r[0] = in_0_r;
    assign x_r[1] = in_1_r;
    assign x_r[2] = in_2_r;
    assign x_r[3] = in_3_r;
    assign x_r[4] = in_4_r;
    assign x_r[5] = in_5_r;
    assign x_r[6] = in_6_r;
    assign x_r[7] = in_7_r;
    assign x_i[0] = in_0_i;
    assign x_i[1] = in_1_i;
    assign x_i[2] = in_2_i;
    assign x_i[3] = in_3_i;
    assign x_i[4] = in_4_i;
    assign x_i[5] = in_5_i;
    assign x_i[6] = in_6_i;
    assign x_i[7] = in_7_i;

    function automatic logic signed [W:0] ext(input logic [W-1:0] v);
        return {v[W-1], v};
    endfunction

    // Butterflies at W+1 bits: twiddle 1 on (p,p+2), twiddle +j on (p+1,p+3)
    always_comb begin
        for (int p = 0; p < 8; p += 4) begin
            f_r[p]   = ext(x_r[p]) + ext(x_r[p+2]);
            f_i[p]   = ext(x_i[p]) + ext(x_i[p+2]);
            f_r[p+2] = ext(x_r[p]) - ext(x_r[p+2]);
            f_i[p+2] = ext(x_i[p]) - ext(x_i[p+2]);
            f_r[p+1] = ext(x_r[p+1]) - ext(x_i[p+3]);
            f_i[p+1] = ext(x_i[p+1]) + ext(x_r[p+3]);
            f_r[p+3] = ext(x_r[p+1]) + ext(x_i[p+3]);
            f_i[p+3] = ext(x_i[p+1]) - ext(x_r[p+3]);
        end
    end

    // Reduce each result to W bits and flag results that do not fit
    always_comb begin
        any_ovf = 1'b0;
        for (int k = 0; k < 8; k++) begin
`ifdef IFFT_STAGE_SCALE_EN
            y_r[k] = f_r[k][W:1];
            y_i[k] = f_i[k][W:1];
`else
            y_r[k] = f_r[k][W-1:0];
            y_i[k] = f_i[k][W-1:0];
            if (f_r[k][W] != f_r[k][W-1] || f_i[k][W] != f_i[k][W-1])
                any_ovf = 1'b1;
`endif
        end
    end

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Skid FIFO: store computed frames, advance pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int e = 0; e < 2; e++) begin
                for (int k = 0; k < 8; k++) begin
                    mem_r[e][k] <= '0;
                    mem_i[e][k] <= '0;
                end
            end
        end else begin
            if (push) begin
                for (int k = 0; k < 8; k++) begin
                    mem_r[wr_ptr][k] <= y_r[k];
                    mem_i[wr_ptr][k] <= y_i[k];
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a new overflow beats a same-edge clear
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (push && any_ovf)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

    assign out_0_r = mem_r[rd_ptr][0];
    assign out_1_r = mem_r[rd_ptr][1];
    assign out_2_r = mem_r[rd_ptr][2];
    assign out_3_r = mem_r[rd_ptr][3];
    assign out_4_r = mem_r[rd_ptr][4];
    assign out_5_r = mem_r[rd_ptr][5];
    assign out_6_r = mem_r[rd_ptr][6];
    assign out_7_r = mem_r[rd_ptr][7];
    assign out_0_i = mem_i[rd_ptr][0];
    assign out_1_i = mem_i[rd_ptr][1];
    assign out_2_i = mem_i[rd_ptr][2];
    assign out_3_i = mem_i[rd_ptr][3];
    assign out_4_i = mem_i[rd_ptr][4];
    assign out_5_i = mem_i[rd_ptr][5];
    assign out_6_i = mem_i[rd_ptr][6];
    assign out_7_i = mem_i[rd_ptr][7];

endmodule

// File: tb/tb_ifft_stage_2_pipe.sv
// Directed bench for ifft_stage_2_pipe (W=8).
// Expectations follow IFFT_STAGE_SCALE_EN when defined.
module tb_ifft_stage_2_pipe;

`ifdef IFFT_STAGE_SCALE_EN
    localparam bit SC = 1'b1;
    localparam int E_R [8] = '{6, 0, 3, 4, 6, 0, 3, 4};
    localparam int E_I [8] = '{0, 1, 0, 0, 4, 1, 2, 0};
    localparam int E35_R   = 100;
    localparam int E35_OVF = 0;
`else
    localparam bit SC = 1'b0;
    localparam int E_R [8] = '{13, 1, 7, 9, 13, 1, 7, 9};
    localparam int E_I [8] = '{0, 3, 0, 1, 8, 3, 4, 1};
    localparam int E35_R   = 200;
    localparam int E35_OVF = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] x_r [8];
    logic [7:0] x_i [8];
    logic [7:0] o_r [8];
    logic [7:0] o_i [8];
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       ovf;
    logic       ovf_clr;
    int         n_run = 0;
    int         n_fail = 0;

    ifft_stage_2_pipe dut (
        .clk(clk), .rst(rst),
        .in_0_r(x_r[0]), .in_1_r(x_r[1]), .in_2_r(x_r[2]), .in_3_r(x_r[3]),
        .in_4_r(x_r[4]), .in_5_r(x_r[5]), .in_6_r(x_r[6]), .in_7_r(x_r[7]),
        .in_0_i(x_i[0]), .in_1_i(x_i[1]), .in_2_i(x_i[2]), .in_3_i(x_i[3]),
        .in_4_i(x_i[4]), .in_5_i(x_i[5]), .in_6_i(x_i[6]), .in_7_i(x_i[7]),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_0_r(o_r[0]), .out_1_r(o_r[1]), .out_2_r(o_r[2]), .out_3_r(o_r[3]),
        .out_4_r(o_r[4]), .out_5_r(o_r[5]), .out_6_r(o_r[6]), .out_7_r(o_r[7]),
        .out_0_i(o_i[0]), .out_1_i(o_i[1]), .out_2_i(o_i[2]), .out_3_i(o_i[3]),
        .out_4_i(o_i[4]), .out_5_i(o_i[5]), .out_6_i(o_i[6]), .out_7_i(o_i[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m8(input int v);
        logic [31:0] t;
        t = v;
        return {24'b0, t[7:0]};
    endfunction

    function automatic int sc(input int v);
        return SC ? (v >>> 1) : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        for (int k = 0; k < 8; k++) begin
            x_r[k] = 8'd0;
            x_i[k] = 8'd0;
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ovf_clr = 1'b0;
        clr_in();
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_out_0_r", o_r[0], 0);
        chk("rst_out_7_i", o_i[7], 0);

        // basic butterflies on both halves
        x_r[0] = 10; x_r[2] = 3; x_r[1] = 5; x_i[1] = 2;
        x_r[3] = 1;  x_i[3] = 4;
        x_r[4] = 10; x_i[4] = 6; x_r[6] = 3; x_i[6] = 2;
        x_r[5] = 5;  x_i[5] = 2; x_r[7] = 1; x_i[7] = 4;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        clr_in();
        chk("lat_out_valid", out_valid, 1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bfly_out_%0d_r", k), o_r[k], m8(E_R[k]));
            chk($sformatf("bfly_out_%0d_i", k), o_i[k], m8(E_I[k]));
        end
        chk("bfly_ovf", ovf, 0);
        step();
        chk("bfly_drained", out_valid, 0);

        // overflow on pair (4,6)
        x_r[4] = 100; x_r[6] = 100;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        clr_in();
        chk("ovf_out_4_r", o_r[4], m8(E35_R));
        chk("ovf_out_6_r", o_r[6], 0);
        chk("ovf_set", ovf, E35_OVF);
        step();
        chk("ovf_held", ovf, E35_OVF);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // back-pressure: third frame refused
        out_ready = 1'b0;
        in_valid = 1'b1;
        x_r[0] = 2;
        step();
        chk("bp_ready_1", in_ready, 1);
        x_r[0] = 4;
        step();
        chk("bp_ready_full", in_ready, 0);
        x_r[0] = 6;
        step();
        chk("bp_ready_still", in_ready, 0);
        chk("bp_head_a", o_r[0], m8(sc(2)));
        chk("bp_head_a_2", o_r[2], m8(sc(2)));
        in_valid = 1'b0;
        clr_in();
        out_ready = 1'b1;
        step();
        chk("bp_ready_back", in_ready, 1);
        chk("bp_head_b", o_r[0], m8(sc(4)));
        chk("bp_valid_b", out_valid, 1);
        step();
        chk("bp_empty", out_valid, 0);

        // streaming: one frame per cycle, in order
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            x_r[0] = 8'(2 * i + 2);
            step();
            chk($sformatf("stream_valid_%0d", i), out_valid, 1);
            chk($sformatf("stream_data_%0d", i), o_r[0], m8(sc(2 * i + 2)));
            chk($sformatf("stream_ready_%0d", i), in_ready, 1);
        end
        in_valid = 1'b0;
        clr_in();
        step();
        chk("stream_end", out_valid, 0);

        // reset with FIFO full discards contents
        out_ready = 1'b0;
        in_valid = 1'b1;
        x_r[0] = 20;
        step();
        x_r[0] = 22;
        step();
        chk("full_in_ready", in_ready, 0);
        chk("full_head", o_r[0], m8(sc(20)));
        x_r[0] = 24;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        clr_in();
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_out_0_r", o_r[0], 0);
        out_ready = 1'b1;
        step();
        chk("rst2_lost", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
